// File: rtl/m_seq_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_seq_gen2                                                   |
// | Description : Start/stop controlled m-sequence (LFSR) chip generator with  |
// |               per-chip hold, single-period or continuous operation.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module m_seq_gen2 #(
  parameter int                LENGTH   = 6,
  parameter logic [LENGTH-1:0] POLYNOME = 6'b000011,
  parameter int                HOLD_W   = 4
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [LENGTH-1:0] seed_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic              mode_i,
  input  logic              stop_i,
  output logic              ready_o,
  output logic              out_o,
  output logic              strobe_o,
  output logic              last_o,
  output logic              err_o
);

  localparam logic [LENGTH-1:0] c_chip_max = {LENGTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state,    w_state;
  logic [LENGTH-1:0]   r_lfsr,     w_lfsr;
  logic [HOLD_W-1:0]   r_hold,     w_hold;
  logic                r_mode,     w_mode;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt;
  logic [LENGTH-1:0]   r_chip_cnt, w_chip_cnt;
  logic                r_stop,     w_stop;
  logic                r_err,      w_err;

  logic                w_chip_end;
  logic                w_last_chip;
  logic [LENGTH-1:0]   w_lfsr_adv;

  assign w_chip_end  = (r_hold_cnt == r_hold);
  assign w_last_chip = (r_chip_cnt == c_chip_max);
  assign w_lfsr_adv  = {^(POLYNOME & r_lfsr), r_lfsr[LENGTH-1:1]};

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= '0;
      r_hold     <= '0;
      r_mode     <= 1'b0;
      r_hold_cnt <= '0;
      r_chip_cnt <= '0;
      r_stop     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_lfsr     <= w_lfsr;
      r_hold     <= w_hold;
      r_mode     <= w_mode;
      r_hold_cnt <= w_hold_cnt;
      r_chip_cnt <= w_chip_cnt;
      r_stop     <= w_stop;
      r_err      <= w_err;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_lfsr     = r_lfsr;
    w_hold     = r_hold;
    w_mode     = r_mode;
    w_hold_cnt = r_hold_cnt;
    w_chip_cnt = r_chip_cnt;
    w_stop     = r_stop;
    w_err      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_stop = 1'b0;
        if (start_i) begin
          if (seed_i != '0) begin
            w_state    = ST_RUN;
            w_lfsr     = seed_i;
            w_hold     = hold_i;
            w_mode     = mode_i;
            w_hold_cnt = '0;
            w_chip_cnt = LENGTH'(1);
          end else begin
            w_err = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (w_chip_end) begin
          // A stop seen on the final cycle of a chip still ends the run here.
          if (r_stop || stop_i || (w_last_chip && !r_mode)) begin
            w_state    = ST_IDLE;
            w_stop     = 1'b0;
            w_hold_cnt = '0;
            w_chip_cnt = '0;
          end else begin
            w_lfsr     = w_lfsr_adv;
            w_hold_cnt = '0;
            w_chip_cnt = w_last_chip ? LENGTH'(1) : (r_chip_cnt + LENGTH'(1));
          end
        end else begin
          w_hold_cnt = r_hold_cnt + HOLD_W'(1);
          w_stop     = r_stop | stop_i;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign ready_o  = (r_state == ST_IDLE);
  assign out_o    = (r_state == ST_RUN) & r_lfsr[0];
  assign strobe_o = (r_state == ST_RUN) && (r_hold_cnt == '0);
  assign last_o   = strobe_o && w_last_chip;
  assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_m_seq_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_m_seq_gen2                                                |
// | Description : Self-checking bench for m_seq_gen2 against a chip-level      |
// |               reference model.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_m_seq_gen2;

  localparam int             LEN  = 6;
  localparam int             N    = 63;
  localparam int             HW   = 4;
  localparam logic [LEN-1:0] POLY = 6'b000011;

  logic           clkin = 1'b0;
  logic           rstn;
  logic           start_i;
  logic [LEN-1:0] seed_i;
  logic [HW-1:0]  hold_i;
  logic           mode_i;
  logic           stop_i;
  logic           ready_o, out_o, strobe_o, last_o, err_o;

  int n_cmp = 0;
  int n_mis = 0;
  bit chips [N];

  always #5 clkin = ~clkin;

  m_seq_gen2 #(.LENGTH(LEN), .POLYNOME(POLY), .HOLD_W(HW)) dut (
    .clkin    (clkin),
    .rstn     (rstn),
    .start_i  (start_i),
    .seed_i   (seed_i),
    .hold_i   (hold_i),
    .mode_i   (mode_i),
    .stop_i   (stop_i),
    .ready_o  (ready_o),
    .out_o    (out_o),
    .strobe_o (strobe_o),
    .last_o   (last_o),
    .err_o    (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One full period of chips, straight from the shift/feedback rule.
  function automatic void gen_chips(input logic [LEN-1:0] seed);
    logic [LEN-1:0] s;
    s = seed;
    for (int i = 0; i < N; i++) begin
      chips[i] = s[0];
      s = {^(POLY & s), s[LEN-1:1]};
    end
  endfunction

  task automatic step;
    @(posedge clkin);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"},  32'(ready_o),  32'd1);
    check({tag, ".out"},    32'(out_o),    32'd0);
    check({tag, ".strobe"}, 32'(strobe_o), 32'd0);
    check({tag, ".last"},   32'(last_o),   32'd0);
  endtask

  // Starts a run, checks every RUN cycle against the model, ends in the first IDLE cycle.
  task automatic run(input string tag, input logic [LEN-1:0] seed, input logic [HW-1:0] hold,
                     input logic mode, input int stop_at,
                     output int ones, output int strobes, output int run_len);
    int L, total, j, ph;
    bit exp_out, exp_stb, exp_last;
    L = int'(hold) + 1;
    ones = 0; strobes = 0; run_len = 0;
    gen_chips(seed);
    if (mode || (stop_at >= 0 && stop_at < N * L))
      total = (stop_at / L + 1) * L;
    else
      total = N * L;
    check({tag, ".rdy0"}, 32'(ready_o), 32'd1);
    start_i = 1'b1; seed_i = seed; hold_i = hold; mode_i = mode; stop_i = 1'b0;
    step;
    for (int k = 0; k < total; k++) begin
      j        = k / L;
      ph       = k % L;
      exp_out  = chips[j % N];
      exp_stb  = (ph == 0);
      exp_last = exp_stb && ((j % N) == N - 1);
      if (out_o !== exp_out || strobe_o !== exp_stb || last_o !== exp_last || ready_o !== 1'b0
          || err_o !== 1'b0)
        $display("  at %s cycle %0d chip %0d", tag, k, j + 1);
      check({tag, ".out"},    32'(out_o),    32'(exp_out));
      check({tag, ".strobe"}, 32'(strobe_o), 32'(exp_stb));
      check({tag, ".last"},   32'(last_o),   32'(exp_last));
      check({tag, ".ready"},  32'(ready_o),  32'd0);
      check({tag, ".err"},    32'(err_o),    32'd0);
      if (strobe_o && out_o) ones++;
      if (strobe_o) strobes++;
      if (!ready_o) run_len++;
      // Config/start noise during RUN must have no effect.
      start_i = 1'($urandom);
      seed_i  = LEN'($urandom);
      hold_i  = HW'($urandom);
      mode_i  = 1'($urandom);
      stop_i  = (k == stop_at);
      step;
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    check_idle({tag, ".end"});
  endtask

  initial begin
    int ones, stbs, rlen, sd, hd, md, sa;
    rstn = 1'b0; start_i = 1'b0; seed_i = '0; hold_i = '0; mode_i = 1'b0; stop_i = 1'b0;
    #3;
    check_idle("reset");
    check("reset.err", 32'(err_o), 32'd0);
    step; step;
    @(negedge clkin) rstn = 1'b1;
    step;
    check_idle("post_reset");

    run("r032", 6'b000001, 4'd0, 1'b0, -1, ones, stbs, rlen);
    check("r032.ones",    32'(ones), 32'd32);
    check("r032.strobes", 32'(stbs), 32'd63);
    check("r032.runlen",  32'(rlen), 32'd63);

    run("r033", 6'b101010, 4'd2, 1'b0, -1, ones, stbs, rlen);
    check("r033.strobes", 32'(stbs), 32'd63);
    check("r033.runlen",  32'(rlen), 32'd189);

    run("r034", 6'b000001, 4'd0, 1'b1, 3 * N - 1, ones, stbs, rlen);
    check("r034.strobes", 32'(stbs), 32'd189);
    check("r034.ones",    32'(ones), 32'd96);

    stop_i = 1'b1;
    step;
    stop_i = 1'b0;
    check_idle("idle_stop");
    step;

    run("r035", 6'b010011, 4'd3, 1'b1, 9 * 4 + 1, ones, stbs, rlen);
    check("r035.runlen",  32'(rlen), 32'd40);
    check("r035.strobes", 32'(stbs), 32'd10);

    start_i = 1'b1; seed_i = '0; hold_i = 4'd5; mode_i = 1'b1;
    step;
    start_i = 1'b0;
    check("r036.err",    32'(err_o),    32'd1);
    check("r036.ready",  32'(ready_o),  32'd1);
    check("r036.strobe", 32'(strobe_o), 32'd0);
    step;
    check("r036.err_off", 32'(err_o), 32'd0);
    check_idle("r036.after");

    start_i = 1'b1; seed_i = 6'b000001; hold_i = 4'd1; mode_i = 1'b1;
    step;
    start_i = 1'b0;
    for (int k = 0; k < 19 * 2; k++) step;
    check("r037.strobe_pre", 32'(strobe_o), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_idle("r037.async");
    check("r037.err", 32'(err_o), 32'd0);
    step; step;
    check_idle("r037.held");
    @(negedge clkin) rstn = 1'b1;
    step;
    run("r037.rerun", 6'b000001, 4'd0, 1'b0, -1, ones, stbs, rlen);
    check("r037.ones",   32'(ones), 32'd32);
    check("r037.runlen", 32'(rlen), 32'd63);

    for (int it = 0; it < 8; it++) begin
      sd = $urandom_range(1, N);
      hd = $urandom_range(0, 3);
      md = $urandom_range(0, 1);
      if (md != 0)
        sa = $urandom_range(0, 2 * N * (hd + 1) - 1);
      else
        sa = ($urandom_range(0, 1) != 0) ? $urandom_range(0, N * (hd + 1) - 1) : -1;
      run($sformatf("rnd%0d", it), LEN'(sd), HW'(hd), 1'(md), sa, ones, stbs, rlen);
      for (int g = $urandom_range(0, 2); g > 0; g--) step;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_seq_gen2.md
M_SEQ_GEN2 -- requirements
Module: m_seq_gen2

Interface
REQ-001 SHALL have parameter LENGTH, default 6, meaning LFSR length in bits; sequence period N = 2^LENGTH-1.
REQ-002 SHALL have parameter POLYNOME, default 6'b000011 (LENGTH bits), meaning feedback tap mask without the leading "1"; must be primitive.
REQ-003 SHALL have parameter HOLD_W, default 4, meaning width of the runtime hold count.
REQ-004 SHALL have port clkin, input, 1 bit, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rstn, input, 1 bit, meaning reset; asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1 bit, meaning start request; qualified by ready_o.
REQ-007 SHALL have port seed_i, input, LENGTH bits, meaning initial LFSR phase, captured on start.
REQ-008 SHALL have port hold_i, input, HOLD_W bits, meaning extra cycles per chip, captured on start.
REQ-009 SHALL have port mode_i, input, 1 bit, meaning 0 = single period, 1 = continuous; captured on start.
REQ-010 SHALL have port stop_i, input, 1 bit, meaning request to end a continuous or single run at the next chip boundary.
REQ-011 SHALL have port ready_o, output, 1 bit, meaning idle and able to accept start.
REQ-012 SHALL have port out_o, output, 1 bit, meaning current chip value.
REQ-013 SHALL have port strobe_o, output, 1 bit, meaning one-cycle pulse on the first cycle of each chip.
REQ-014 SHALL have port last_o, output, 1 bit, meaning one-cycle pulse coincident with strobe_o of chip N of a period.
REQ-015 SHALL have port err_o, output, 1 bit, meaning one-cycle pulse when a start with seed_i == 0 is rejected.

Function
REQ-016 SHALL implement two states: IDLE (ready_o=1, out_o=0) and RUN (ready_o=0).
REQ-017 SHALL accept a start in IDLE when start_i=1 and seed_i!=0: capture seed, hold, mode; enter RUN next cycle.
REQ-018 SHALL reject start with seed_i==0: remain IDLE, pulse err_o in the following cycle, capture nothing.
REQ-019 SHALL output the first chip (seed[0]) with strobe_o=1 in the cycle after acceptance (latency 1).
REQ-020 SHALL advance the LFSR per chip: out = s[0]; s_next = {^(POLYNOME & s), s[LENGTH-1:1]}.
REQ-021 SHALL hold each chip on out_o for hold+1 cycles; hold=0 gives one chip per cycle; strobe_o is high only in the first of those cycles.
REQ-022 SHALL count chips 1..N per period with a LENGTH-bit counter; last_o is asserted with strobe_o of chip N.
REQ-023 In single mode, SHALL return to IDLE after the final hold cycle of chip N; ready_o=1 and out_o=0 in the next cycle; total RUN time N*(hold+1) cycles.
REQ-024 In continuous mode, SHALL begin chip 1 of the next period immediately after chip N, with no gap; the LFSR state equals seed again (period N) and the chip counter wraps to 1.
REQ-025 SHALL latch stop_i seen on any RUN cycle and enter IDLE after the final hold cycle of the current chip; no partial chips.
REQ-026 SHALL treat stop at the chip-N boundary in continuous mode as termination; chip 1 of a new period is not emitted.
REQ-027 SHALL ignore stop_i in IDLE; start_i in RUN SHALL be ignored, with no change to captured config.
REQ-028 SHALL ignore changes to seed_i, hold_i and mode_i during RUN.
REQ-029 SHALL allow a new start in the same cycle ready_o returns high; back-to-back runs then have a one-cycle IDLE gap.

Reset
REQ-030 On rstn=0, SHALL asynchronously force IDLE: ready_o=1, out_o=0, strobe_o=0, last_o=0, err_o=0, chip counter and hold counter cleared, stop latch cleared.
REQ-031 SHALL abort any run by reset mid-operation with no further strobes; the first start after reset release behaves as from power-up.

Verification
REQ-032 SHALL be verified with: seed 6'b000001, hold 0, mode 0 -> chips 1,0,0,... over 63 cycles; 32 ones, 31 zeros; last_o on cycle 63; ready_o=1 on cycle 64.
REQ-033 SHALL be verified with: seed 6'b101010, hold 2, mode 0 -> each chip held 3 cycles, strobe_o every 3rd cycle, 63 strobes, RUN length 189 cycles.
REQ-034 SHALL be verified with: seed 6'b000001, hold 0, mode 1 over 3 periods -> chips 64..126 equal chips 1..63; last_o every 63 cycles; no gap.
REQ-035 SHALL be verified with: stop_i pulsed mid-chip 10, hold 3 -> chip 10 completes all 4 cycles, then ready_o=1, out_o=0, no strobe for chip 11.
REQ-036 SHALL be verified with: start_i with seed_i=0 -> err_o=1 for one cycle, ready_o stays 1, no strobe_o.
REQ-037 SHALL be verified with: rstn low during chip 20 -> all outputs at reset values immediately, without waiting for a clock edge; a restart with seed 6'b000001 reproduces REQ-032 exactly.
